// File: rtl/data_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : data_frame_parser
// Description : Receive-side parser for the channel data-frame stream.
//               Hunts for a header word (DIN[63:48] == 16'hAAAA), forwards
//               FRAME_LEN payload words, then takes the next word as the
//               footer (DIN[15:0] == 16'h5555). On each footer, oversize
//               header or truncated frame it pulses INFO_VALID with the
//               decoded frame info and the error flags. No backpressure.
// Ports       : CLK, RESET (sync, active high)
//               iVALID / DIN        - input stream word and qualifier
//               oREADY              - 1 whenever not in reset
//               DATA_VALID/DATA_OUT - payload word, 1 cycle after DIN
//               INFO_VALID          - one pulse per completed/aborted frame
//               CH_ID, TIME_STAMP, BASELINE, THRESHOLD, FRAME_LEN - frame info
//               FRAME_ERR           - [0] bad footer ID, [1] length > MAX,
//                                     [2] truncated, [3] channel mismatch
//               GOOD_FRAME_CNT      - error-free frame count (wraps)
//               SYNC_LOST           - sticky, words dropped while hunting
// Options     : FRAME_PARSER_CH_CHECK_EN - when defined, a header whose
//               channel differs from CHANNEL_ID flags FRAME_ERR[3] at the
//               footer; when undefined FRAME_ERR[3] is always 0.
// Revision    : 1.0 - initial release
// ============================================================================
module data_frame_parser #(
    parameter int MAX_FRAME_LENGTH = 200,
    parameter int CHANNEL_ID       = 0,
    parameter int DIN_WIDTH        = 64,
    parameter int LEN_WIDTH        = 12
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 iVALID,
    input  logic [DIN_WIDTH-1:0] DIN,
    output logic                 oREADY,
    output logic                 DATA_VALID,
    output logic [DIN_WIDTH-1:0] DATA_OUT,
    output logic                 INFO_VALID,
    output logic [3:0]           CH_ID,
    output logic [47:0]          TIME_STAMP,
    output logic [15:0]          BASELINE,
    output logic [15:0]          THRESHOLD,
    output logic [LEN_WIDTH-1:0] FRAME_LEN,
    output logic [3:0]           FRAME_ERR,
    output logic [31:0]          GOOD_FRAME_CNT,
    output logic                 SYNC_LOST
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] C_ST_HUNT = 2'd0;
    localparam logic [1:0] C_ST_DATA = 2'd1;
    localparam logic [1:0] C_ST_FOOT = 2'd2;

    localparam logic [15:0]          C_HEADER_ID = 16'hAAAA;
    localparam logic [15:0]          C_FOOTER_ID = 16'h5555;
    localparam logic [LEN_WIDTH-1:0] C_MAX_LEN   = MAX_FRAME_LENGTH[LEN_WIDTH-1:0];
    localparam logic [LEN_WIDTH-1:0] C_LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]           C_EXP_CH    = CHANNEL_ID[3:0];

`ifdef FRAME_PARSER_CH_CHECK_EN
    localparam logic C_CH_CHECK = 1'b1;
`else
    localparam logic C_CH_CHECK = 1'b0;
`endif

    localparam logic [3:0] C_ERR_LEN   = 4'b0010;
    localparam logic [3:0] C_ERR_TRUNC = 4'b0100;

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    logic [1:0]           state_q,      state_d;
    logic [LEN_WIDTH-1:0] cnt_q,        cnt_d;
    logic                 ch_err_q,     ch_err_d;
    logic                 oready_q,     oready_d;
    logic                 data_valid_q, data_valid_d;
    logic [DIN_WIDTH-1:0] data_out_q,   data_out_d;
    logic                 info_valid_q, info_valid_d;
    logic [3:0]           ch_id_q,      ch_id_d;
    logic [47:0]          ts_q,         ts_d;
    logic [15:0]          baseline_q,   baseline_d;
    logic [15:0]          threshold_q,  threshold_d;
    logic [LEN_WIDTH-1:0] frame_len_q,  frame_len_d;
    logic [3:0]           frame_err_q,  frame_err_d;
    logic [31:0]          good_cnt_q,   good_cnt_d;
    logic                 sync_lost_q,  sync_lost_d;

    // ------------------------------------------------------------------
    // Input word decode
    // ------------------------------------------------------------------
    logic                 w_is_header;
    logic                 w_bad_footer;
    logic [LEN_WIDTH-1:0] w_len;
    logic                 w_len_too_long;
    logic                 w_len_zero;
    logic                 w_ch_mismatch;

    assign w_is_header    = (DIN[63:48] == C_HEADER_ID);
    assign w_bad_footer   = (DIN[15:0] != C_FOOTER_ID);
    assign w_len          = DIN[LEN_WIDTH-1:0];
    assign w_len_too_long = (w_len > C_MAX_LEN);
    assign w_len_zero     = (w_len == '0);
    // Constant-folds to 0 when the channel check is compiled out.
    assign w_ch_mismatch  = C_CH_CHECK & (DIN[47:44] != C_EXP_CH);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= C_ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_HUNT: begin
                if (iVALID && w_is_header && !w_len_too_long) begin
                    state_d = w_len_zero ? C_ST_FOOT : C_ST_DATA;
                end
            end
            C_ST_DATA: begin
                if (!iVALID) begin
                    state_d = C_ST_HUNT;
                end else if (cnt_q == C_LEN_ONE) begin
                    state_d = C_ST_FOOT;
                end
            end
            // Footer or abort: either way the next cycle hunts again,
            // which lets a header follow a footer with no gap.
            C_ST_FOOT: state_d = C_ST_HUNT;
            default:   state_d = C_ST_HUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        ch_err_d     = ch_err_q;
        oready_d     = 1'b1;
        data_valid_d = 1'b0;
        data_out_d   = data_out_q;
        info_valid_d = 1'b0;
        ch_id_d      = ch_id_q;
        ts_d         = ts_q;
        baseline_d   = baseline_q;
        threshold_d  = threshold_q;
        frame_len_d  = frame_len_q;
        frame_err_d  = 4'b0000;
        good_cnt_d   = good_cnt_q;
        sync_lost_d  = sync_lost_q;

        case (state_q)
            C_ST_HUNT: begin
                if (iVALID) begin
                    if (w_is_header) begin
                        ch_id_d      = DIN[47:44];
                        ts_d[31:0]   = DIN[43:12];
                        frame_len_d  = w_len;
                        ch_err_d     = w_ch_mismatch;
                        cnt_d        = w_len;
                        if (w_len_too_long) begin
                            info_valid_d = 1'b1;
                            frame_err_d  = C_ERR_LEN;
                        end
                    end else begin
                        sync_lost_d = 1'b1;
                    end
                end
            end
            C_ST_DATA: begin
                if (iVALID) begin
                    // Positional: header/footer look-alikes are payload here.
                    data_valid_d = 1'b1;
                    data_out_d   = DIN;
                    cnt_d        = cnt_q - C_LEN_ONE;
                end else begin
                    info_valid_d = 1'b1;
                    frame_err_d  = C_ERR_TRUNC;
                end
            end
            C_ST_FOOT: begin
                info_valid_d = 1'b1;
                if (iVALID) begin
                    baseline_d  = DIN[63:48];
                    threshold_d = DIN[47:32];
                    ts_d[47:32] = DIN[31:16];
                    frame_err_d = {ch_err_q, 2'b00, w_bad_footer};
                end else begin
                    frame_err_d = C_ERR_TRUNC;
                end
            end
            default: begin
                info_valid_d = 1'b0;
            end
        endcase

        // Counted on the next values so the count already includes the
        // frame in the cycle its INFO_VALID pulse is visible.
        if (info_valid_d && (frame_err_d == 4'b0000)) begin
            good_cnt_d = good_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q        <= '0;
            ch_err_q     <= 1'b0;
            oready_q     <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            info_valid_q <= 1'b0;
            ch_id_q      <= '0;
            ts_q         <= '0;
            baseline_q   <= '0;
            threshold_q  <= '0;
            frame_len_q  <= '0;
            frame_err_q  <= '0;
            good_cnt_q   <= '0;
            sync_lost_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ch_err_q     <= ch_err_d;
            oready_q     <= oready_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            info_valid_q <= info_valid_d;
            ch_id_q      <= ch_id_d;
            ts_q         <= ts_d;
            baseline_q   <= baseline_d;
            threshold_q  <= threshold_d;
            frame_len_q  <= frame_len_d;
            frame_err_q  <= frame_err_d;
            good_cnt_q   <= good_cnt_d;
            sync_lost_q  <= sync_lost_d;
        end
    end

    assign oREADY         = oready_q;
    assign DATA_VALID     = data_valid_q;
    assign DATA_OUT       = data_out_q;
    assign INFO_VALID     = info_valid_q;
    assign CH_ID          = ch_id_q;
    assign TIME_STAMP     = ts_q;
    assign BASELINE       = baseline_q;
    assign THRESHOLD      = threshold_q;
    assign FRAME_LEN      = frame_len_q;
    assign FRAME_ERR      = frame_err_q;
    assign GOOD_FRAME_CNT = good_cnt_q;
    assign SYNC_LOST      = sync_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_data_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_frame_parser
// Description : Directed bench for data_frame_parser. Expected payload words
//               and frame-info records are queued as stimulus is driven and
//               compared when the DUT strobes DATA_VALID / INFO_VALID.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_frame_parser;

`ifdef FRAME_PARSER_CH_CHECK_EN
    localparam bit CH_CHECK = 1'b1;
`else
    localparam bit CH_CHECK = 1'b0;
`endif
    localparam logic [3:0] EXP_CH = 4'd2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        iVALID = 1'b0;
    logic [63:0] DIN = '0;
    logic        oREADY, DATA_VALID, INFO_VALID, SYNC_LOST;
    logic [63:0] DATA_OUT;
    logic [3:0]  CH_ID, FRAME_ERR;
    logic [47:0] TIME_STAMP;
    logic [15:0] BASELINE, THRESHOLD;
    logic [11:0] FRAME_LEN;
    logic [31:0] GOOD_FRAME_CNT;

    data_frame_parser #(
        .MAX_FRAME_LENGTH (200),
        .CHANNEL_ID       (2),
        .DIN_WIDTH        (64),
        .LEN_WIDTH        (12)
    ) u_dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .iVALID         (iVALID),
        .DIN            (DIN),
        .oREADY         (oREADY),
        .DATA_VALID     (DATA_VALID),
        .DATA_OUT       (DATA_OUT),
        .INFO_VALID     (INFO_VALID),
        .CH_ID          (CH_ID),
        .TIME_STAMP     (TIME_STAMP),
        .BASELINE       (BASELINE),
        .THRESHOLD      (THRESHOLD),
        .FRAME_LEN      (FRAME_LEN),
        .FRAME_ERR      (FRAME_ERR),
        .GOOD_FRAME_CNT (GOOD_FRAME_CNT),
        .SYNC_LOST      (SYNC_LOST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  ch;
        logic [47:0] ts;
        logic [15:0] base;
        logic [15:0] thr;
        logic [11:0] len;
        logic [3:0]  err;
        logic [31:0] good;
    } info_t;

    logic [63:0] exp_data[$];
    info_t       exp_info[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Values the parser should currently hold in its info registers.
    logic [3:0]  lat_ch   = '0;
    logic [31:0] lat_tslo = '0;
    logic [15:0] lat_tshi = '0;
    logic [15:0] lat_base = '0;
    logic [15:0] lat_thr  = '0;
    logic [11:0] lat_len  = '0;
    logic [31:0] exp_good = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one input word; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic [63:0] d);
        iVALID = v;
        DIN    = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_info(input logic [3:0] err);
        info_t e;
        if (err == 4'b0000) exp_good++;
        e.ch   = lat_ch;
        e.ts   = {lat_tshi, lat_tslo};
        e.base = lat_base;
        e.thr  = lat_thr;
        e.len  = lat_len;
        e.err  = err;
        e.good = exp_good;
        exp_info.push_back(e);
    endtask

    task automatic send_header(input logic [3:0] ch, input logic [31:0] tslo, input logic [11:0] len);
        drive(1'b1, {16'hAAAA, ch, tslo, len});
        lat_ch   = ch;
        lat_tslo = tslo;
        lat_len  = len;
    endtask

    task automatic send_payload(input int n, input bit lookalike);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            if (lookalike && i == 0) w = 64'hAAAA_0000_0000_0001;
            if (lookalike && i == 1) w = 64'h0000_0000_0000_5555;
            exp_data.push_back(w);
            drive(1'b1, w);
        end
    endtask

    task automatic send_footer(input logic [3:0] ch, input logic [15:0] tshi, input logic [15:0] base,
                               input logic [15:0] thr, input logic [15:0] fid);
        logic [3:0] err;
        drive(1'b1, {base, thr, tshi, fid});
        lat_tshi = tshi;
        lat_base = base;
        lat_thr  = thr;
        err      = {CH_CHECK && (ch != EXP_CH), 2'b00, fid != 16'h5555};
        push_info(err);
    endtask

    task automatic send_frame(input logic [3:0] ch, input logic [31:0] tslo, input logic [11:0] len,
                              input logic [15:0] tshi, input logic [15:0] base, input logic [15:0] thr,
                              input logic [15:0] fid, input bit lookalike);
        send_header(ch, tslo, len);
        send_payload(int'(len), lookalike);
        send_footer(ch, tshi, base, thr, fid);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_oready"},     oREADY,         0);
        chk({tag, "_data_valid"}, DATA_VALID,     0);
        chk({tag, "_data_out"},   DATA_OUT,       0);
        chk({tag, "_info_valid"}, INFO_VALID,     0);
        chk({tag, "_ch_id"},      CH_ID,          0);
        chk({tag, "_time_stamp"}, TIME_STAMP,     0);
        chk({tag, "_baseline"},   BASELINE,       0);
        chk({tag, "_threshold"},  THRESHOLD,      0);
        chk({tag, "_frame_len"},  FRAME_LEN,      0);
        chk({tag, "_frame_err"},  FRAME_ERR,      0);
        chk({tag, "_good_cnt"},   GOOD_FRAME_CNT, 0);
        chk({tag, "_sync_lost"},  SYNC_LOST,      0);
    endtask

    // Scoreboard side: compare whatever the DUT strobes out.
    always @(negedge CLK) begin
        if (DATA_VALID) begin
            if (exp_data.size() == 0) begin
                chk("data_valid_unexpected", DATA_VALID, 0);
            end else begin
                chk("payload_word", DATA_OUT, exp_data.pop_front());
            end
        end
        if (INFO_VALID) begin
            if (exp_info.size() == 0) begin
                chk("info_valid_unexpected", INFO_VALID, 0);
            end else begin
                info_t e;
                e = exp_info.pop_front();
                chk("info_ch_id",      CH_ID,          e.ch);
                chk("info_time_stamp", TIME_STAMP,     e.ts);
                chk("info_baseline",   BASELINE,       e.base);
                chk("info_threshold",  THRESHOLD,      e.thr);
                chk("info_frame_len",  FRAME_LEN,      e.len);
                chk("info_frame_err",  FRAME_ERR,      e.err);
                chk("info_good_cnt",   GOOD_FRAME_CNT, e.good);
            end
        end
    end

    initial begin
        // Reset state
        RESET = 1'b1;
        repeat (3) drive(1'b0, '0);
        check_all_zero("reset");
        RESET = 1'b0;
        drive(1'b0, '0);
        chk("oready_after_reset", oREADY, 1);

        // Single frame from the reference example
        send_frame(4'd0, 32'h1234_5678, 12'd3, 16'hABCD, 16'h07FF, 16'h0FFF, 16'h5555, 1'b0);
        drive(1'b0, '0);
        chk("ts_single",       TIME_STAMP,     48'hABCD_1234_5678);
        chk("good_cnt_single", GOOD_FRAME_CNT, 1);
        drive(1'b0, '0);

        // Zero-length frame then a 2-word frame with look-alike payload, no gap
        send_frame(4'd2, 32'h0000_0010, 12'd0, 16'h0011, 16'h0100, 16'h0200, 16'h5555, 1'b0);
        send_frame(4'd2, 32'h0000_0020, 12'd2, 16'h0022, 16'h0300, 16'h0400, 16'h5555, 1'b1);
        drive(1'b0, '0);
        drive(1'b0, '0);
        chk("sync_lost_clean", SYNC_LOST, 0);

        // Oversize length (MAX + 1), then stray words are dropped
        send_header(4'd2, 32'h0BAD_0BAD, 12'd201);
        push_info(4'b0010);
        drive(1'b1, 64'h0123_4567_89AB_CDEF);
        drive(1'b1, 64'h1111_2222_3333_5555);
        drive(1'b0, '0);
        chk("sync_lost_set", SYNC_LOST, 1);
        drive(1'b0, '0);

        // Truncated after 2 of 5 payload words, then a good frame
        send_header(4'd2, 32'hCAFE_0001, 12'd5);
        send_payload(2, 1'b0);
        drive(1'b0, '0);
        push_info(4'b0100);
        drive(1'b0, '0);
        send_frame(4'd2, 32'hCAFE_0002, 12'd1, 16'h5A5A, 16'h0123, 16'h0456, 16'h5555, 1'b0);
        drive(1'b0, '0);

        // Bad footer ID
        send_frame(4'd2, 32'hF00D_0003, 12'd2, 16'h1357, 16'h2468, 16'h9BDF, 16'h5554, 1'b0);
        drive(1'b0, '0);

        // Channel other than the configured one
        send_frame(4'd3, 32'hC4A7_0004, 12'd1, 16'h7777, 16'h0008, 16'h0009, 16'h5555, 1'b0);
        drive(1'b0, '0);

        // Reset in the middle of the payload: no INFO_VALID, everything cleared
        send_header(4'd2, 32'hDEAD_BEEF, 12'd4);
        send_payload(2, 1'b0);
        RESET = 1'b1;
        drive(1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
        check_all_zero("midreset");
        lat_ch = '0; lat_tslo = '0; lat_tshi = '0; lat_base = '0; lat_thr = '0; lat_len = '0;
        exp_good = '0;
        RESET = 1'b0;
        drive(1'b0, '0);
        drive(1'b0, '0);

        // Recovery after reset
        send_frame(4'd2, 32'h0000_0099, 12'd200, 16'h0099, 16'h0A0A, 16'h0B0B, 16'h5555, 1'b0);
        repeat (4) drive(1'b0, '0);
        chk("sync_lost_after_reset", SYNC_LOST, 0);

        chk("data_queue_drained", exp_data.size(), 0);
        chk("info_queue_drained", exp_info.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_frame_parser.md
# data_frame_parser

Receive-side counterpart of the channel data-frame generator. Consumes the 64-bit header/data/footer word stream, validates frame structure, and forwards the payload words. On each footer it presents the decoded frame info (channel, 48-bit timestamp, baseline, threshold, length) with error flags. It sits downstream of the generator's read side, in front of the readout/DMA packer, and applies no backpressure.

## Interface
- MAX_FRAME_LENGTH, 200: largest legal payload length in 64-bit words.
- CHANNEL_ID, 0: expected 4-bit channel ID.
- DIN_WIDTH, 64: stream word width.
- LEN_WIDTH, 12: width of the length field, header[11:0].
- CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- iVALID  in  1  DIN qualifier; contiguous for the whole frame.
- DIN  in  64  frame word.
- oREADY  out  1  always 1 when not in reset.
- DATA_VALID  out  1  payload word strobe.
- DATA_OUT  out  64  payload word.
- INFO_VALID  out  1  one-cycle pulse per completed or aborted frame.
- CH_ID  out  4  header[47:44].
- TIME_STAMP  out  48  {footer[31:16], header[43:12]}.
- BASELINE  out  16  footer[63:48].
- THRESHOLD  out  16  footer[47:32].
- FRAME_LEN  out  LEN_WIDTH  header[11:0].
- FRAME_ERR  out  4  flags: [0] bad footer ID, [1] length > MAX, [2] truncated (iVALID dropped), [3] channel mismatch.
- GOOD_FRAME_CNT  out  32  count of error-free frames; wraps.
- SYNC_LOST  out  1  sticky; set when non-header words are discarded while hunting.

## Operation
- Header word: DIN[63:48]==16'hAAAA. Footer word: DIN[15:0]==16'h5555.
- State HUNT:
  - On iVALID with a header word: latch CH_ID, header[43:12] and FRAME_LEN.
  - FRAME_LEN > MAX_FRAME_LENGTH: pulse INFO_VALID with FRAME_ERR[1], stay in HUNT.
  - FRAME_LEN == 0: go to FOOT.
  - Otherwise: load the payload counter with FRAME_LEN and go to DATA.
  - Any other valid word is dropped and sets SYNC_LOST.
- State DATA:
  - Each valid word is forwarded on DATA_OUT/DATA_VALID and decrements the counter.
  - On the last word (counter==1) go to FOOT.
  - Words are positional only: a payload word that happens to look like a header or footer is still forwarded.
- State FOOT: the next valid word is the footer.
  - Latch BASELINE, THRESHOLD and TIME_STAMP[47:32].
  - If DIN[15:0]!=16'h5555, set FRAME_ERR[0].
  - Pulse INFO_VALID and return to HUNT.
- iVALID low while in DATA or FOOT: abort.
  - Pulse INFO_VALID with FRAME_ERR[2]; info fields keep the last latched values.
  - Go to HUNT; payload already forwarded is not retracted.
- GOOD_FRAME_CNT increments on every INFO_VALID with FRAME_ERR==0.
- A header arriving in the cycle right after a footer is accepted normally, so back-to-back frames have no gap.

## Timing
- Reset values: oREADY=0 (during RESET), DATA_VALID=0, DATA_OUT=0, INFO_VALID=0, CH_ID=0, TIME_STAMP=0, BASELINE=0, THRESHOLD=0, FRAME_LEN=0, FRAME_ERR=0, GOOD_FRAME_CNT=0, SYNC_LOST=0, state=HUNT.
- All outputs are registered.
- DIN to DATA_OUT latency: 1 cycle.
- Footer accepted at edge N: INFO_VALID high for exactly cycle N+1, with all info fields and FRAME_ERR valid in the same cycle.
- Info fields hold until the next frame's header/footer latch; FRAME_ERR is meaningful only while INFO_VALID is high.
- RESET mid-frame: the frame is discarded in the next cycle with no INFO_VALID; SYNC_LOST clears.
- Counter width is LEN_WIDTH. The length compare is unsigned.

## Configuration
- FRAME_PARSER_CH_CHECK_EN defined: a header with CH_ID!=CHANNEL_ID sets FRAME_ERR[3]. The frame is still parsed and its payload forwarded, and the error is reported with the footer.
- Macro undefined: no channel comparison is made and FRAME_ERR[3] is tied to 0.

## Test plan
- Single frame: header 0xAAAA_0_12345678_003, three payload words, footer 0x07FF_0FFF_ABCD_5555.
  - DATA_VALID high for 3 cycles with the words in order.
  - INFO_VALID one cycle after the footer: TIME_STAMP=0xABCD12345678, BASELINE=0x07FF, THRESHOLD=0x0FFF, FRAME_LEN=3, FRAME_ERR=0, GOOD_FRAME_CNT=1.
- Zero-length frame immediately followed by a 2-word frame, no idle gap.
  - Two INFO_VALID pulses, both error-free; DATA_VALID high for 2 cycles.
- Header with length 201: INFO_VALID with FRAME_ERR=4'b0010; the next valid words are dropped and SYNC_LOST=1.
- iVALID drops after 2 of 5 payload words.
  - INFO_VALID with FRAME_ERR[2]=1; GOOD_FRAME_CNT unchanged.
  - The next valid header parses correctly.
- Footer ID 0x5554: FRAME_ERR[0]=1.
- FRAME_PARSER_CH_CHECK_EN build with CHANNEL_ID=2 and a header carrying CH_ID=3: FRAME_ERR=4'b1000.
- RESET asserted mid-payload: all outputs return to 0 and no INFO_VALID is emitted.
